// File: rtl/rv_decode_stage_if.sv
// ---------------------------------------------------------------------------
// rv_decode_stage_if
//   Bundles every non-clock, non-reset signal of the RV32I decode stage:
//   the fetch-side valid/ready handshake, the decoded bundle sent to execute,
//   the writeback request from WB, and the RegF read/write port owned by the
//   decode stage.
//
//   Modports:
//     slave  - the decode stage itself (rv_decode_stage).
//     master - the environment around it (fetch, execute, WB and RegF).
//
//   XLEN must match the XLEN of the rv_decode_stage instance it connects to.
// ---------------------------------------------------------------------------
interface rv_decode_stage_if #(
  parameter int XLEN = 32
);
  // Fetch handshake
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;

  // Decoded bundle to execute
  logic            out_valid;
  logic            out_ready;
  logic [6:0]      out_opcode;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_imm;
  logic [XLEN-1:0] out_rs1_val;
  logic [XLEN-1:0] out_rs2_val;
  logic            out_illegal;

  // Writeback request
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  // RegF port
  logic            rw;
  logic            wr;
  logic [4:0]      Ad_rs1;
  logic [4:0]      Ad_rs2;
  logic [4:0]      Ad_rd;
  logic [XLEN-1:0] rd_data_in;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;

  modport slave (
    input  in_valid, in_instr, out_ready, wb_valid, wb_rd, wb_data,
           rs1_data, rs2_data,
    output in_ready, out_valid, out_opcode, out_funct3, out_funct7, out_rd,
           out_imm, out_rs1_val, out_rs2_val, out_illegal,
           rw, wr, Ad_rs1, Ad_rs2, Ad_rd, rd_data_in
  );

  modport master (
    output in_valid, in_instr, out_ready, wb_valid, wb_rd, wb_data,
           rs1_data, rs2_data,
    input  in_ready, out_valid, out_opcode, out_funct3, out_funct7, out_rd,
           out_imm, out_rs1_val, out_rs2_val, out_illegal,
           rw, wr, Ad_rs1, Ad_rs2, Ad_rd, rd_data_in
  );
endinterface

// File: rtl/rv_decode_stage.sv
// ---------------------------------------------------------------------------
// rv_decode_stage
//   RV32I instruction-decode stage sitting directly upstream of RegF.
//   Accepts an instruction from fetch, decodes fields and the sign-extended
//   immediate, stalls on RAW hazards against a pending-write scoreboard,
//   reads RegF (one-cycle read latency) and presents the operand bundle to
//   execute. WB write requests pass straight through to the RegF write port.
//
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous, active-low reset
//     bus  - rv_decode_stage_if.slave: fetch handshake (in_*), execute
//            bundle (out_*), writeback request (wb_*), RegF port
//            (rw, wr, Ad_rs1, Ad_rs2, Ad_rd, rd_data_in, rs1_data, rs2_data)
//
//   Flow: IDLE (accept) -> CHECK (hazard, rw) -> READ (capture) -> VALID.
// ---------------------------------------------------------------------------
module rv_decode_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic              clk,
  input  logic              rst,
  rv_decode_stage_if.slave  bus
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {IDLE, CHECK, READ, VALID} state_e;

  // Decode results latched with the instruction so CHECK works from flops.
  typedef struct packed {
    logic            illegal;
    logic            use_rs1;
    logic            use_rs2;
    logic            writes_rd;
    logic [XLEN-1:0] imm;
  } decode_t;

  function automatic decode_t decode(input logic [31:0] instr);
    decode_t d;
    d           = '0;
    d.use_rs1   = 1'b1;
    d.writes_rd = 1'b1;
    case (instr[6:0])
      OP_LUI, OP_AUIPC: begin
        d.use_rs1 = 1'b0;
        d.imm     = XLEN'($signed({instr[31:12], 12'b0}));
      end
      OP_JAL: begin
        d.use_rs1 = 1'b0;
        d.imm     = XLEN'($signed({instr[31], instr[19:12], instr[20],
                                   instr[30:21], 1'b0}));
      end
      OP_JALR, OP_LOAD, OP_IMM, OP_SYSTEM: begin
        d.imm = XLEN'($signed(instr[31:20]));
      end
      OP_STORE: begin
        d.use_rs2   = 1'b1;
        d.writes_rd = 1'b0;
        d.imm       = XLEN'($signed({instr[31:25], instr[11:7]}));
      end
      OP_BRANCH: begin
        d.use_rs2   = 1'b1;
        d.writes_rd = 1'b0;
        d.imm       = XLEN'($signed({instr[31], instr[7], instr[30:25],
                                     instr[11:8], 1'b0}));
      end
      OP_REG: begin
        d.use_rs2 = 1'b1;
      end
      default: begin
        // Unknown opcode: no operands, no destination, zero immediate.
        d.illegal   = 1'b1;
        d.use_rs1   = 1'b0;
        d.writes_rd = 1'b0;
      end
    endcase
    return d;
  endfunction

  state_e          state_q;
  logic            in_ready_q;
  logic [31:0]     instr_q;
  decode_t         dec_q;
  logic [XLEN-1:0] rs1_val_q;
  logic [XLEN-1:0] rs2_val_q;
  logic [NREG-1:0] sb_q;
  logic [NREG-1:0] sb_next;

  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rd;
  logic       hazard;
  logic       issue;
  logic       set_en;
  logic       wr;

  assign rs1 = instr_q[19:15];
  assign rs2 = instr_q[24:20];
  assign rd  = instr_q[11:7];

  // NOTE: every variable assigned in an always_comb gets a default first so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    hazard = 1'b0;
    if (!dec_q.illegal) begin
      if (dec_q.use_rs1 && (rs1 != 5'd0) && sb_q[rs1]) hazard = 1'b1;
      if (dec_q.use_rs2 && (rs2 != 5'd0) && sb_q[rs2]) hazard = 1'b1;
    end
  end

  assign issue  = (state_q == CHECK) && !hazard;
  assign set_en = issue && dec_q.writes_rd && (rd != 5'd0);
  assign wr     = bus.wb_valid && (bus.wb_rd != 5'd0);

  // Clear from WB first, then set from issue, so a same-edge set wins.
  always_comb begin
    sb_next = sb_q;
    if (wr)     sb_next[bus.wb_rd] = 1'b0;
    if (set_en) sb_next[rd]        = 1'b1;
    sb_next[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
      instr_q    <= '0;
      dec_q      <= '0;
      rs1_val_q  <= '0;
      rs2_val_q  <= '0;
      sb_q       <= '0;
    end else begin
      sb_q <= sb_next;
      case (state_q)
        IDLE: begin
          // in_ready rises one cycle after reset release, then stays up
          // until an instruction is taken.
          in_ready_q <= 1'b1;
          if (in_ready_q && bus.in_valid) begin
            instr_q    <= bus.in_instr;
            dec_q      <= decode(bus.in_instr);
            in_ready_q <= 1'b0;
            state_q    <= CHECK;
          end
        end
        CHECK: begin
          if (!hazard) state_q <= READ;
        end
        READ: begin
          // RegF data is valid the cycle after rw.
          rs1_val_q <= bus.rs1_data;
          rs2_val_q <= bus.rs2_data;
          state_q   <= VALID;
        end
        VALID: begin
          if (bus.out_ready) begin
            in_ready_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = (state_q == VALID);
  assign bus.out_opcode  = instr_q[6:0];
  assign bus.out_funct3  = instr_q[14:12];
  assign bus.out_funct7  = instr_q[31:25];
  assign bus.out_rd      = rd;
  assign bus.out_imm     = dec_q.imm;
  assign bus.out_illegal = dec_q.illegal;
  assign bus.out_rs1_val = rs1_val_q;
  assign bus.out_rs2_val = rs2_val_q;

  assign bus.rw         = issue;
  assign bus.Ad_rs1     = rs1;
  assign bus.Ad_rs2     = rs2;
  assign bus.wr         = wr;
  assign bus.Ad_rd      = bus.wb_rd;
  assign bus.rd_data_in = bus.wb_data;

endmodule

// File: tb/tb_rv_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_rv_decode_stage
//   Directed bench for rv_decode_stage. A small RegF model answers reads one
//   cycle after rw and applies WB writes; all expected values are hand-derived
//   from the instruction encodings and the preloaded register contents
//   (x0 = 0, xN = 0x1000_0000 + N until written).
// ---------------------------------------------------------------------------
module tb_rv_decode_stage;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   lat;
  logic [31:0] regs [32];

  rv_decode_stage_if bus ();

  rv_decode_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // RegF model: one-cycle read latency; data is junk outside the read cycle.
  always @(posedge clk) begin
    if (bus.wr) regs[bus.Ad_rd] <= bus.rd_data_in;
    bus.rs1_data <= bus.rw ? regs[bus.Ad_rs1] : 32'hDEADBEEF;
    bus.rs2_data <= bus.rw ? regs[bus.Ad_rs2] : 32'hDEADBEEF;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic accept(input string tag, input logic [31:0] instr);
    int n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".in_ready"}, bus.in_ready, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
  endtask

  task automatic wait_out(input int start, output int cycles);
    cycles = start;
    while (!bus.out_valid && cycles < 30) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic check_bundle(input string tag, input logic [31:0] instr,
                              input logic [31:0] imm, input logic [31:0] rs1v,
                              input logic [31:0] rs2v, input logic ill);
    check({tag, ".out_valid"}, bus.out_valid, 1'b1);
    check({tag, ".opcode"}, bus.out_opcode, instr[6:0]);
    check({tag, ".funct3"}, bus.out_funct3, instr[14:12]);
    check({tag, ".funct7"}, bus.out_funct7, instr[31:25]);
    check({tag, ".rd"}, bus.out_rd, instr[11:7]);
    check({tag, ".imm"}, bus.out_imm, imm);
    check({tag, ".rs1_val"}, bus.out_rs1_val, rs1v);
    check({tag, ".rs2_val"}, bus.out_rs2_val, rs2v);
    check({tag, ".illegal"}, bus.out_illegal, ill);
    check({tag, ".in_ready"}, bus.in_ready, 1'b0);
  endtask

  task automatic release_out(input string tag);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, ".drop_valid"}, bus.out_valid, 1'b0);
    check({tag, ".back_ready"}, bus.in_ready, 1'b1);
  endtask

  // Hazard-free instruction: rw in the first CHECK cycle, bundle 3 cycles
  // after accept.
  task automatic simple_txn(input string tag, input logic [31:0] instr,
                            input logic [31:0] imm, input logic [31:0] rs1v,
                            input logic [31:0] rs2v, input logic ill);
    int cyc;
    accept(tag, instr);
    check({tag, ".rw"}, bus.rw, 1'b1);
    check({tag, ".ad_rs1"}, bus.Ad_rs1, instr[19:15]);
    check({tag, ".ad_rs2"}, bus.Ad_rs2, instr[24:20]);
    wait_out(1, cyc);
    check({tag, ".latency"}, cyc, 3);
    check_bundle(tag, instr, imm, rs1v, rs2v, ill);
  endtask

  initial begin
    regs[0] = '0;
    for (int i = 1; i < 32; i++) regs[i] = 32'h1000_0000 + i;
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.out_ready = 1'b0;
    bus.wb_valid  = 1'b0;
    bus.wb_rd     = '0;
    bus.wb_data   = '0;

    // Reset: everything at zero, including in_ready.
    repeat (3) @(negedge clk);
    check("rst.in_ready", bus.in_ready, 1'b0);
    check("rst.out_valid", bus.out_valid, 1'b0);
    check("rst.rw", bus.rw, 1'b0);
    check("rst.wr", bus.wr, 1'b0);
    check("rst.ad_rs1", bus.Ad_rs1, 5'd0);
    check("rst.ad_rs2", bus.Ad_rs2, 5'd0);
    check("rst.imm", bus.out_imm, 32'h0);
    check("rst.illegal", bus.out_illegal, 1'b0);
    check("rst.opcode", bus.out_opcode, 7'h0);
    check("rst.rd", bus.out_rd, 5'd0);
    check("rst.rs1_val", bus.out_rs1_val, 32'h0);
    check("rst.rs2_val", bus.out_rs2_val, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("rst.release_ready", bus.in_ready, 1'b1);

    // ADDI x1,x0,5 : sets scoreboard[1]; rs2 field = x5.
    simple_txn("addi", 32'h00500093, 32'h00000005, 32'h0, 32'h10000005, 1'b0);
    release_out("addi");

    // ADD x2,x1,x1 : stalls on x1 until WB writes it.
    accept("add", 32'h00108133);
    repeat (3) begin
      check("add.stall_rw", bus.rw, 1'b0);
      @(negedge clk);
    end
    check("add.stall_rw", bus.rw, 1'b0);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd1;
    bus.wb_data  = 32'h11111111;
    #1;
    check("add.wr", bus.wr, 1'b1);
    check("add.ad_rd", bus.Ad_rd, 5'd1);
    check("add.rd_data_in", bus.rd_data_in, 32'h11111111);
    @(negedge clk);
    bus.wb_valid = 1'b0;
    bus.wb_rd    = '0;
    bus.wb_data  = '0;
    check("add.rw_after_wb", bus.rw, 1'b1);
    wait_out(1, lat);
    check("add.latency_after_wb", lat, 3);
    check_bundle("add", 32'h00108133, 32'h0, 32'h11111111, 32'h11111111, 1'b0);
    release_out("add");

    // BEQ x0,x0,-4 : negative B immediate, rd field x29 must not be marked.
    simple_txn("beq", 32'hFE000EE3, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b0);
    release_out("beq");

    // SW x1,8(x1) : x1 is free again after the writeback.
    simple_txn("sw", 32'h0010A423, 32'h00000008, 32'h11111111, 32'h11111111,
               1'b0);
    release_out("sw");

    // Illegal opcode with rs1=rs2=x2 (pending) and rd=x3: no stall, no mark.
    simple_txn("illegal", 32'h002101FF, 32'h0, 32'h10000002, 32'h10000002,
               1'b1);
    release_out("illegal");

    // ADD x4,x3,x29 : proves neither x3 nor x29 was marked; then hold.
    simple_txn("add4", 32'h01D18233, 32'h0, 32'h10000003, 32'h1000001D, 1'b0);
    repeat (5) begin
      @(negedge clk);
      check("hold.out_valid", bus.out_valid, 1'b1);
      check("hold.in_ready", bus.in_ready, 1'b0);
      check("hold.rd", bus.out_rd, 5'd4);
      check("hold.rs1_val", bus.out_rs1_val, 32'h10000003);
      check("hold.rs2_val", bus.out_rs2_val, 32'h1000001D);
      check("hold.imm", bus.out_imm, 32'h0);
    end
    release_out("add4");

    // ADDI x6,x0,1 with a WB clear of x6 on the issue edge: set must win.
    accept("addi6", 32'h00100313);
    check("addi6.rw", bus.rw, 1'b1);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd6;
    bus.wb_data  = 32'h66666666;
    @(negedge clk);
    bus.wb_valid = 1'b0;
    bus.wb_rd    = '0;
    bus.wb_data  = '0;
    wait_out(2, lat);
    check("addi6.latency", lat, 3);
    check_bundle("addi6", 32'h00100313, 32'h00000001, 32'h0, 32'h11111111,
                 1'b0);
    release_out("addi6");

    // ADD x5,x6,x6 stalls on x6; reset while in CHECK.
    accept("add5", 32'h006302B3);
    repeat (3) begin
      check("add5.stall_rw", bus.rw, 1'b0);
      check("add5.stall_ready", bus.in_ready, 1'b0);
      @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);
    check("midrst.out_valid", bus.out_valid, 1'b0);
    check("midrst.in_ready", bus.in_ready, 1'b0);
    check("midrst.rw", bus.rw, 1'b0);
    check("midrst.ad_rs1", bus.Ad_rs1, 5'd0);
    check("midrst.rd", bus.out_rd, 5'd0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst.release_ready", bus.in_ready, 1'b1);

    // Scoreboard was cleared: the same ADD now issues at once.
    simple_txn("add5_retry", 32'h006302B3, 32'h0, 32'h66666666, 32'h66666666,
               1'b0);
    release_out("add5_retry");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
- Instruction-decode stage that sits directly upstream of the RegF register file and owns all of its ports.
- Accepts a 32-bit RV32I instruction from fetch over a valid/ready handshake and decodes its fields and immediate.
- Issues the RegF read, holds on RAW hazards using a pending-write scoreboard, and presents a decoded operand bundle to execute.
- Forwards writeback requests from the WB stage onto the RegF write port.

Parameters:
- XLEN, 32, data width of register values and immediates.
- NREG, 32, number of architectural registers; also the scoreboard width.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  fetch has an instruction.
- in_ready  out  1  stage can accept an instruction.
- in_instr  in  32  instruction word.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts the bundle.
- out_opcode  out  7  instr[6:0].
- out_funct3  out  3  instr[14:12].
- out_funct7  out  7  instr[31:25].
- out_rd  out  5  destination register.
- out_imm  out  XLEN  sign-extended immediate.
- out_rs1_val  out  XLEN  rs1 operand.
- out_rs2_val  out  XLEN  rs2 operand.
- out_illegal  out  1  opcode is not RV32I.
- wb_valid  in  1  writeback request.
- wb_rd  in  5  writeback register.
- wb_data  in  XLEN  writeback data.
- rw  out  1  RegF read strobe.
- wr  out  1  RegF write strobe.
- Ad_rs1  out  5  RegF read address 1.
- Ad_rs2  out  5  RegF read address 2.
- Ad_rd  out  5  RegF write address.
- rd_data_in  out  XLEN  RegF write data.
- rs1_data  in  XLEN  RegF read data 1.
- rs2_data  in  XLEN  RegF read data 2.

Behaviour:
- Reset (rst=0 at a rising edge):
  - State goes to IDLE and the scoreboard is cleared.
  - All outputs are 0, including the latched instruction and the operand registers.
  - Reset mid-operation discards any in-flight instruction.
- RegF read timing: rs1_data and rs2_data are valid in the cycle after the cycle in which rw=1.
- FSM:
  - IDLE: in_ready=1. When in_valid=1, latch in_instr and go to CHECK.
  - CHECK: compute the hazard from the registered scoreboard.
    - rs1 is used by every opcode except LUI, AUIPC and JAL.
    - rs2 is used by R, S and B opcodes.
    - A hazard exists when a used source register is nonzero and its scoreboard bit is set.
    - On a hazard, stay in CHECK with rw=0.
    - With no hazard, drive rw=1 for one cycle, set scoreboard[rd] if the instruction writes rd, and go to READ.
  - READ: capture rs1_data and rs2_data into out_rs1_val and out_rs2_val; go to VALID.
  - VALID: out_valid=1 and all outputs are held stable. When out_ready=1, go to IDLE.
- Minimum latency is 3 cycles from accept to out_valid. Throughput is one instruction per 4 cycles.
- Ad_rs1 = latched instr[19:15] and Ad_rs2 = latched instr[24:20], driven in every state.
- Writes rd:
  - All opcodes except S, B and illegal opcodes write rd.
  - rd=0 never sets a scoreboard bit, and scoreboard bit 0 is always 0.
- Immediate, sign-extended to XLEN from bit 31:
  - I-type: instr[31:20].
  - S-type: {instr[31:25], instr[11:7]}.
  - B-type: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U-type: {instr[31:12], 12'b0}.
  - J-type: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R-type and illegal opcodes: 0.
- Legal opcodes: 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 1110011. Any other opcode sets out_illegal=1, skips the hazard check and sets no scoreboard bit.
- Writeback path (combinational):
  - wr = wb_valid & (wb_rd != 0); Ad_rd = wb_rd; rd_data_in = wb_data.
  - When wr=1, scoreboard[wb_rd] clears at that edge.
- Same-edge events:
  - If a scoreboard set and a clear target the same register at one edge, the set wins.
  - A clear takes effect the following cycle, so CHECK sees the register as free one cycle after wb_valid. The RegF write has landed by then, so no bypass is needed.

Test Plan:
- Reset: hold rst=0 for 3 cycles -> all outputs 0, in_ready=0. Release -> in_ready=1 in IDLE.
- Send 0x00500093 (ADDI x1,x0,5) with RegF x0=0 -> out_valid 3 cycles after accept, out_rd=1, out_imm=0x00000005, out_rs1_val=0, scoreboard[1]=1.
- With x1 pending, send 0x00108133 (ADD x2,x1,x1) -> the stage stays in CHECK with rw=0. Pulse wb_valid with wb_rd=1, wb_data=0x11111111 -> wr=1 and Ad_rd=1 that cycle. One cycle later rw=1, and the bundle arrives with both operands 0x11111111.
- Send 0xFE000EE3 (BEQ x0,x0,-4) -> out_imm=0xFFFFFFFC, no scoreboard bit set. Send 0x0010A423 (SW x1,8(x1)) -> out_imm=0x00000008.
- Send 0x0000007F -> out_illegal=1, out_imm=0, no stall even if scoreboard bits are set.
- Hold out_ready=0 for 5 cycles in VALID -> all outputs stable and in_ready=0. Assert rst=0 mid-CHECK -> IDLE next cycle, scoreboard clear, out_valid=0.
